// File: rtl/ctrl_seq_pkg.sv
// ctrl_seq_pkg: shared types and constants for the ctrl_seq instruction sequencer.
//  - state_t     : sequencer FSM states
//  - OP_*        : 4-bit opcode encodings driven onto control_bus
//  - is_legal_op : 1 for opcodes the sequencer may issue or act on (0..8 and HALT)
package ctrl_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        WAIT   = 3'd2,
        DECODE = 3'd3,
        EXEC   = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_PUSH = 4'd4;
    localparam logic [3:0] OP_POP  = 4'd5;
    localparam logic [3:0] OP_JMP  = 4'd6;
    localparam logic [3:0] OP_JZ   = 4'd7;
    localparam logic [3:0] OP_JS   = 4'd8;
    localparam logic [3:0] OP_HALT = 4'd15;

    // Codes 4'b1001..4'b1110 are reserved and treated as illegal.
    function automatic logic is_legal_op(input logic [3:0] op);
        return (op <= OP_JS) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/ctrl_seq.sv
// ctrl_seq: instruction sequencer for the stack-machine execute unit.
//  Fetches the instruction at pc from a synchronous ROM, decodes it onto
//  control_bus/addr_const, holds en until fin_sig, and repeats until HALT.
// Optional feature macro: CTRL_SEQ_WDT_EN (EXEC watchdog of WDT_CYC cycles).
// Ports:
//  clk, rstn            clock (rising edge), asynchronous active-low reset
//  start                1-cycle pulse, starts execution from IDLE/HALT
//  pc                   program counter supplied by the execute unit
//  imem_addr/imem_r_en  ROM address and read strobe (data valid one cycle later)
//  imem_data            {opcode[3:0], operand[DATA_LEN-1:0]}
//  en/control_bus/addr_const  execute handshake towards the execute unit
//  fin_sig              execute unit finished the current instruction
//  busy/done/err        status: running, halted, sticky error
//  inst_cnt             retired instruction count, saturating
module ctrl_seq
    import ctrl_seq_pkg::*;
#(
    parameter int DATA_LEN = 8,
    parameter int INST_CAP = 20,
    parameter int WDT_CYC  = 64,
    localparam int PC_W    = $clog2(INST_CAP) + 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [PC_W-1:0]       pc,
    output logic [PC_W-1:0]       imem_addr,
    output logic                  imem_r_en,
    input  logic [DATA_LEN+3:0]   imem_data,
    output logic                  en,
    output logic [3:0]            control_bus,
    output logic [DATA_LEN-1:0]   addr_const,
    input  logic                  fin_sig,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [15:0]           inst_cnt
);

    localparam logic [PC_W-1:0] PC_LIMIT = PC_W'(INST_CAP);

    if (INST_CAP < 1 || WDT_CYC < 1) begin : g_bad_cfg
        $error("ctrl_seq: INST_CAP and WDT_CYC must be at least 1");
    end

    state_t                state_r, state_s;
    logic [PC_W-1:0]       imem_addr_r, imem_addr_s;
    logic                  imem_r_en_r, imem_r_en_s;
    logic                  en_r, en_s;
    logic [3:0]            cb_r, cb_s;
    logic [DATA_LEN-1:0]   ac_r, ac_s;
    logic                  busy_r, busy_s;
    logic                  done_r, done_s;
    logic                  err_r, err_s;
    logic [15:0]           cnt_r, cnt_s;
    logic [3:0]            op_s;

`ifdef CTRL_SEQ_WDT_EN
    localparam int            WDT_W    = $clog2(WDT_CYC + 1);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYC - 1);
    logic [WDT_W-1:0]         wdt_r, wdt_s;
`endif

    assign op_s = imem_data[DATA_LEN +: 4];

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_s     = state_r;
        imem_addr_s = imem_addr_r;
        imem_r_en_s = 1'b0;
        en_s        = 1'b0;
        cb_s        = cb_r;
        ac_s        = ac_r;
        err_s       = err_r;
        cnt_s       = cnt_r;
`ifdef CTRL_SEQ_WDT_EN
        wdt_s       = wdt_r;
`endif
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = FETCH;
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH: begin
                // An out-of-range pc halts without touching the ROM.
                if (pc >= PC_LIMIT) begin
                    state_s = HALT;
                    err_s   = 1'b1;
                end else begin
                    imem_addr_s = pc;
                    imem_r_en_s = 1'b1;
                    state_s     = WAIT;
                end
            end
            WAIT: begin
                state_s = DECODE;
            end
            DECODE: begin
                if (op_s == OP_HALT) begin
                    state_s = HALT;
                end else if (!is_legal_op(op_s)) begin
                    state_s = HALT;
                    err_s   = 1'b1;
                end else begin
                    cb_s    = op_s;
                    ac_s    = imem_data[DATA_LEN-1:0];
                    en_s    = 1'b1;
                    state_s = EXEC;
`ifdef CTRL_SEQ_WDT_EN
                    wdt_s   = '0;
`endif
                end
            end
            EXEC: begin
                if (fin_sig) begin
                    en_s    = 1'b0;
                    cnt_s   = (cnt_r == 16'hFFFF) ? cnt_r : cnt_r + 16'd1;
                    state_s = FETCH;
                end
`ifdef CTRL_SEQ_WDT_EN
                else if (wdt_r == WDT_LAST) begin
                    en_s    = 1'b0;
                    err_s   = 1'b1;
                    state_s = HALT;
                end
`endif
                else begin
                    en_s    = 1'b1;
                    state_s = EXEC;
`ifdef CTRL_SEQ_WDT_EN
                    wdt_s   = wdt_r + 1'b1;
`endif
                end
            end
            HALT: begin
                if (start) begin
                    state_s = FETCH;
                    err_s   = 1'b0;
                    cnt_s   = 16'd0;
                end else begin
                    state_s = HALT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        // Status flags follow the state being entered so they line up with it.
        busy_s = (state_s == FETCH) || (state_s == WAIT) ||
                 (state_s == DECODE) || (state_s == EXEC);
        done_s = (state_s == HALT);
    end

    // Registered outputs and datapath.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            imem_addr_r <= '0;
            imem_r_en_r <= 1'b0;
            en_r        <= 1'b0;
            cb_r        <= 4'b0000;
            ac_r        <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            cnt_r       <= 16'd0;
        end else begin
            imem_addr_r <= imem_addr_s;
            imem_r_en_r <= imem_r_en_s;
            en_r        <= en_s;
            cb_r        <= cb_s;
            ac_r        <= ac_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            err_r       <= err_s;
            cnt_r       <= cnt_s;
        end
    end

`ifdef CTRL_SEQ_WDT_EN
    // Watchdog counter: EXEC cycles elapsed for the current instruction.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wdt_r <= '0;
        end else begin
            wdt_r <= wdt_s;
        end
    end
`endif

    assign imem_addr   = imem_addr_r;
    assign imem_r_en   = imem_r_en_r;
    assign en          = en_r;
    assign control_bus = cb_r;
    assign addr_const  = ac_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign err         = err_r;
    assign inst_cnt    = cnt_r;

endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: scoreboard bench for ctrl_seq with a ROM model and an execute-unit model.
module tb_ctrl_seq;

    localparam int DL   = 8;
    localparam int PC_W = 6;

    typedef struct packed {
        logic [3:0]  cb;
        logic [7:0]  ac;
        logic [7:0]  len;   // expected en-high cycles, 0 = not checked
    } issue_t;

    typedef struct packed {
        logic        err;
        logic [15:0] cnt;
    } end_t;

    logic            clk = 1'b0;
    logic            rstn;
    logic            start;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] imem_addr;
    logic            imem_r_en;
    logic [DL+3:0]   imem_data;
    logic            en;
    logic [3:0]      control_bus;
    logic [DL-1:0]   addr_const;
    logic            fin_sig;
    logic            busy, done, err;
    logic [15:0]     inst_cnt;

    logic [DL+3:0]   rom [64];
    issue_t          exp_issue [$];
    end_t            exp_end [$];

    int              n_vec = 0;
    int              n_bad = 0;
    int              fin_delay = 1;
    bit              fin_enable = 1'b1;
    bit              saw_ren = 1'b0;

    ctrl_seq #(.DATA_LEN(DL), .INST_CAP(20), .WDT_CYC(8)) dut (
        .clk(clk), .rstn(rstn), .start(start), .pc(pc),
        .imem_addr(imem_addr), .imem_r_en(imem_r_en), .imem_data(imem_data),
        .en(en), .control_bus(control_bus), .addr_const(addr_const),
        .fin_sig(fin_sig), .busy(busy), .done(done), .err(err), .inst_cnt(inst_cnt)
    );

    always #5 clk = ~clk;

    // Synchronous ROM model.
    always @(posedge clk) begin
        if (imem_r_en) imem_data <= rom[imem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Execute-unit model: raises fin_sig after fin_delay en cycles, then advances pc.
    initial begin
        int en_cyc;
        en_cyc = 0;
        fin_sig = 1'b0;
        forever begin
            @(negedge clk);
            if (en) begin
                if (fin_enable && en_cyc == fin_delay) fin_sig = 1'b1;
                else fin_sig = 1'b0;
                en_cyc++;
            end else begin
                if (fin_sig) pc = pc + 6'd1;
                fin_sig = 1'b0;
                en_cyc = 0;
            end
        end
    end

    // Monitor: compares each issued instruction and each halt against the queues.
    initial begin
        bit     prev_en, prev_done, in_issue;
        int     run;
        issue_t cur;
        end_t   e;
        prev_en = 1'b0; prev_done = 1'b0; in_issue = 1'b0; run = 0; cur = '0;
        forever begin
            @(negedge clk);
            if (imem_r_en) saw_ren = 1'b1;
            if (!rstn) begin
                prev_en = 1'b0; prev_done = 1'b0; in_issue = 1'b0; run = 0;
            end else begin
                if (en && !prev_en) begin
                    if (exp_issue.size() == 0) begin
                        n_vec++; n_bad++;
                        $display("FAIL unexpected_issue: got cb=%0h ac=%0h expected none",
                                 control_bus, addr_const);
                    end else begin
                        cur = exp_issue.pop_front();
                        chk("issue_control_bus", 32'(control_bus), 32'(cur.cb));
                        chk("issue_addr_const", 32'(addr_const), 32'(cur.ac));
                        in_issue = 1'b1;
                    end
                    run = 1;
                end else if (en) begin
                    run++;
                end else if (prev_en && in_issue) begin
                    if (cur.len != 8'd0) chk("en_high_cycles", 32'(run), 32'(cur.len));
                    in_issue = 1'b0;
                end
                if (done && !prev_done) begin
                    if (exp_end.size() == 0) begin
                        n_vec++; n_bad++;
                        $display("FAIL unexpected_halt: got err=%0b cnt=%0d expected none",
                                 err, inst_cnt);
                    end else begin
                        e = exp_end.pop_front();
                        chk("halt_err", 32'(err), 32'(e.err));
                        chk("halt_inst_cnt", 32'(inst_cnt), 32'(e.cnt));
                        chk("halt_busy", 32'(busy), 32'd0);
                    end
                end
                prev_en = en;
                prev_done = done;
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 200; i++) begin
            if (done) break;
            @(negedge clk);
        end
        if (!done) begin
            n_vec++; n_bad++;
            $display("FAIL %s_timeout: got done=0 expected done=1", name);
        end
        @(negedge clk);
    endtask

    task automatic wait_en(input string name);
        for (int i = 0; i < 50; i++) begin
            if (en) break;
            @(negedge clk);
        end
        if (!en) begin
            n_vec++; n_bad++;
            $display("FAIL %s_timeout: got en=0 expected en=1", name);
        end
    endtask

    initial begin
        logic [3:0] illegal_ops [2];
        illegal_ops[0] = 4'h9;
        illegal_ops[1] = 4'hE;
        for (int i = 0; i < 64; i++) rom[i] = {4'hF, 8'h00};
        rstn = 1'b0; start = 1'b0; pc = 6'd0;
        repeat (2) @(negedge clk);
        chk("rst_en", 32'(en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_imem_r_en", 32'(imem_r_en), 32'd0);
        chk("rst_control_bus", 32'(control_bus), 32'd0);
        chk("rst_addr_const", 32'(addr_const), 32'd0);
        chk("rst_inst_cnt", 32'(inst_cnt), 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // {ADD, HALT}, fin one cycle after en rises -> en high 2 cycles.
        rom[0] = {4'h0, 8'h05}; rom[1] = {4'hF, 8'h00};
        pc = 6'd0; fin_delay = 1;
        exp_issue.push_back('{4'h0, 8'h05, 8'd2});
        exp_end.push_back('{1'b0, 16'd1});
        pulse_start();
        wait_done("add_halt");
        chk("add_halt_cb_not_halt", 32'(control_bus), 32'h0);
        chk("add_halt_imem_addr", 32'(imem_addr), 32'd1);

        // PUSH 2A as a single-cycle instruction, then HALT fetched from pc 1.
        rom[0] = {4'h4, 8'h2A};
        pc = 6'd0; fin_delay = 0;
        exp_issue.push_back('{4'h4, 8'h2A, 8'd1});
        exp_end.push_back('{1'b0, 16'd1});
        pulse_start();
        wait_done("push");
        chk("push_next_imem_addr", 32'(imem_addr), 32'd1);
        chk("push_cb", 32'(control_bus), 32'h4);

        // Three-instruction program, fin after 3 en cycles each.
        rom[0] = {4'h1, 8'h11}; rom[1] = {4'h7, 8'h33};
        rom[2] = {4'h8, 8'hC4}; rom[3] = {4'hF, 8'h00};
        pc = 6'd0; fin_delay = 2;
        exp_issue.push_back('{4'h1, 8'h11, 8'd3});
        exp_issue.push_back('{4'h7, 8'h33, 8'd3});
        exp_issue.push_back('{4'h8, 8'hC4, 8'd3});
        exp_end.push_back('{1'b0, 16'd3});
        pulse_start();
        wait_done("prog3");

        // Illegal opcodes at both ends of the reserved range.
        for (int k = 0; k < 2; k++) begin
            rom[0] = {illegal_ops[k], 8'h77};
            pc = 6'd0;
            exp_end.push_back('{1'b1, 16'd0});
            pulse_start();
            wait_done("illegal");
        end

        // Last valid pc executes; pc == INST_CAP halts with err and no ROM read.
        rom[19] = {4'hF, 8'h00};
        pc = 6'd19;
        exp_end.push_back('{1'b0, 16'd0});
        pulse_start();
        wait_done("pc_last");
        chk("pc_last_imem_addr", 32'(imem_addr), 32'd19);
        pc = 6'd20;
        @(negedge clk); saw_ren = 1'b0;
        exp_end.push_back('{1'b1, 16'd0});
        pulse_start();
        wait_done("pc_over");
        chk("pc_over_no_rom_read", 32'(saw_ren), 32'd0);

        // Reset in the middle of EXEC, then restart from the current pc.
        rom[0] = {4'h3, 8'h3C}; rom[1] = {4'hF, 8'h00};
        pc = 6'd0; fin_enable = 1'b0;
        exp_issue.push_back('{4'h3, 8'h3C, 8'd0});
        pulse_start();
        wait_en("rst_exec");
        pulse_start();   // start while busy must be ignored
        chk("busy_start_ignored_en", 32'(en), 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("midrst_en", 32'(en), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_control_bus", 32'(control_bus), 32'd0);
        @(negedge clk);
        #2 rstn = 1'b1;
        fin_enable = 1'b1; fin_delay = 1;
        exp_issue.push_back('{4'h3, 8'h3C, 8'd2});
        exp_end.push_back('{1'b0, 16'd1});
        pulse_start();
        wait_done("restart");

`ifdef CTRL_SEQ_WDT_EN
        // Watchdog: fin never arrives, en drops after WDT_CYC cycles.
        rom[0] = {4'h0, 8'h01};
        pc = 6'd0; fin_enable = 1'b0;
        exp_issue.push_back('{4'h0, 8'h01, 8'd8});
        exp_end.push_back('{1'b1, 16'd0});
        pulse_start();
        wait_done("wdt");
        rom[0] = {4'hF, 8'h00};
        fin_enable = 1'b1;
        exp_end.push_back('{1'b0, 16'd0});
        pulse_start();
        chk("wdt_start_clears_err", 32'(err), 32'd0);
        wait_done("wdt_clear");
`endif

        repeat (3) @(negedge clk);
        chk("issue_queue_drained", 32'(exp_issue.size()), 32'd0);
        chk("halt_queue_drained", 32'(exp_end.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
